// File: rtl/bp_lite_to_burst.sv
// Lite-to-Burst converter: buffers one Lite message {header, data} and replays it as a header
// on the header channel plus LSB-first narrow beats on the data channel, with no bypass path.
// Header layout (LSB first): msg_type[3:0], size[6:4], addr, payload.
module bp_lite_to_burst #(
    parameter int          paddr_width_p    = 40,
    parameter int          payload_width_p  = 16,
    parameter int          in_data_width_p  = 512,
    parameter int          out_data_width_p = 64,
    parameter logic [15:0] payload_mask_p   = '0,
    localparam int out_msg_header_width_lp = payload_width_p + paddr_width_p + 7,
    localparam int in_msg_width_lp         = out_msg_header_width_lp + in_data_width_p
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [in_msg_width_lp-1:0]         in_msg_i,
    input  logic                               in_msg_v_i,
    output logic                               in_msg_ready_and_o,
    output logic [out_msg_header_width_lp-1:0] out_msg_header_o,
    output logic                               out_msg_header_v_o,
    input  logic                               out_msg_header_ready_and_i,
    output logic [out_data_width_p-1:0]        out_msg_data_o,
    output logic                               out_msg_data_v_o,
    input  logic                               out_msg_data_ready_and_i
);

    localparam int burst_words_lp   = in_data_width_p / out_data_width_p;
    localparam int cnt_width_lp     = (burst_words_lp > 1) ? $clog2(burst_words_lp) : 1;
    localparam int out_bytes_log_lp = $clog2(out_data_width_p / 8);

    if (in_data_width_p <= out_data_width_p) begin : g_chk_ratio
        $error("bp_lite_to_burst: in_data_width_p must exceed out_data_width_p");
    end
    if ((in_data_width_p % out_data_width_p) != 0) begin : g_chk_multiple
        $error("bp_lite_to_burst: in_data_width_p must be a multiple of out_data_width_p");
    end

    logic [out_msg_header_width_lp-1:0] in_header;
    logic [in_data_width_p-1:0]         in_data;
    logic [3:0]                         in_msg_type;
    logic [2:0]                         in_size;
    logic [cnt_width_lp-1:0]            last_next;

    logic [out_msg_header_width_lp-1:0] header_r;
    logic [in_data_width_p-1:0]         data_r;
    logic                               hdr_pend_r;
    logic                               data_pend_r;
    logic [cnt_width_lp-1:0]            beat_r;
    logic [cnt_width_lp-1:0]            last_r;

    logic in_fire;
    logic hdr_fire;
    logic data_fire;

    assign in_header   = in_msg_i[in_msg_width_lp-1 -: out_msg_header_width_lp];
    assign in_data     = in_msg_i[in_data_width_p-1:0];
    assign in_msg_type = in_header[3:0];
    assign in_size     = in_header[6:4];

    // Beat count follows the request size, at least one beat and never more than the Lite width holds.
    always_comb begin
        int beats;
        beats = 1;
        if (int'(in_size) > out_bytes_log_lp) begin
            beats = 1 << (int'(in_size) - out_bytes_log_lp);
        end
        if (beats > burst_words_lp) begin
            beats = burst_words_lp;
        end
        last_next = cnt_width_lp'(beats - 1);
    end

    assign in_msg_ready_and_o = reset_n_i & ~hdr_pend_r & ~data_pend_r;
    assign out_msg_header_v_o = reset_n_i & hdr_pend_r;
    assign out_msg_data_v_o   = reset_n_i & data_pend_r;
    assign out_msg_header_o   = header_r;
    assign out_msg_data_o     = data_r[beat_r*out_data_width_p +: out_data_width_p];

    assign in_fire   = in_msg_v_i & in_msg_ready_and_o;
    assign hdr_fire  = out_msg_header_v_o & out_msg_header_ready_and_i;
    assign data_fire = out_msg_data_v_o & out_msg_data_ready_and_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            hdr_pend_r  <= 1'b0;
            data_pend_r <= 1'b0;
            beat_r      <= '0;
            last_r      <= '0;
        end else if (in_fire) begin
            hdr_pend_r  <= 1'b1;
            data_pend_r <= payload_mask_p[in_msg_type];
            beat_r      <= '0;
            last_r      <= last_next;
        end else begin
            if (hdr_fire) begin
                hdr_pend_r <= 1'b0;
            end
            if (data_fire) begin
                beat_r <= beat_r + cnt_width_lp'(1);
                if (beat_r == last_r) begin
                    data_pend_r <= 1'b0;
                end
            end
        end
    end

    // The message buffer needs no reset: its contents only matter while a pend flag is set.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            header_r <= in_header;
            data_r   <= in_data;
        end
    end

endmodule

// File: tb/tb_bp_lite_to_burst.sv
// Directed bench for bp_lite_to_burst: each scenario task drives messages, collects the header and
// data beats, and compares them with hand-computed expectations.
module tb_bp_lite_to_burst;

    localparam int PAW = 40;
    localparam int PLW = 16;
    localparam int HW  = PLW + PAW + 7;
    localparam int IDW = 512;
    localparam int ODW = 64;
    localparam logic [15:0] MASK = 16'h0002;
    localparam logic [3:0] T_READ  = 4'd0;
    localparam logic [3:0] T_WRITE = 4'd1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [HW+IDW-1:0] in_msg = '0;
    logic             in_v = 1'b0;
    logic             in_ready;
    logic [HW-1:0]    hdr_o;
    logic             hv;
    logic             hr = 1'b0;
    logic [ODW-1:0]   data_o;
    logic             dv;
    logic             dr = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [HW-1:0]  got_hdr;
    logic [ODW-1:0] got_beats [0:15];
    int             got_hdr_cnt, got_beat_cnt, stable_err, busy_accept_err;
    bit             timed_out, first_hv, first_dv, ready_after, ever_dv;

    bp_lite_to_burst #(
        .paddr_width_p(PAW), .payload_width_p(PLW), .in_data_width_p(IDW),
        .out_data_width_p(ODW), .payload_mask_p(MASK)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .in_msg_i(in_msg), .in_msg_v_i(in_v), .in_msg_ready_and_o(in_ready),
        .out_msg_header_o(hdr_o), .out_msg_header_v_o(hv), .out_msg_header_ready_and_i(hr),
        .out_msg_data_o(data_o), .out_msg_data_v_o(dv), .out_msg_data_ready_and_i(dr)
    );

    always #5 clk = ~clk;

    function automatic logic [HW-1:0] make_hdr(input logic [3:0] mtype, input logic [2:0] size,
                                               input logic [PAW-1:0] addr, input logic [PLW-1:0] pl);
        return {pl, addr, size, mtype};
    endfunction

    function automatic int exp_beats(input logic [3:0] mtype, input logic [2:0] size);
        if (!MASK[mtype]) return 0;
        case (size)
            3'd0, 3'd1, 3'd2, 3'd3: return 1;
            3'd4: return 2;
            3'd5: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [IDW-1:0] counting_data();
        logic [IDW-1:0] d;
        for (int i = 0; i < IDW/ODW; i++) d[i*ODW +: ODW] = ODW'(i);
        return d;
    endfunction

    function automatic logic [IDW-1:0] random_data();
        logic [IDW-1:0] d;
        for (int i = 0; i < IDW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Sends one message, then plays consumer on both channels with the given stall percentages.
    task automatic run_msg(input logic [HW-1:0] hdr, input logic [IDW-1:0] data,
                           input int hst, input int dst);
        int  cyc;
        bit  done, ph, pd;
        logic [HW-1:0]  prev_hdr;
        logic [ODW-1:0] prev_data;
        got_hdr = '0; got_hdr_cnt = 0; got_beat_cnt = 0; stable_err = 0; busy_accept_err = 0;
        timed_out = 0; ever_dv = 0; ready_after = 0; ph = 0; pd = 0;
        prev_hdr = '0; prev_data = '0;
        @(negedge clk);
        in_msg = {hdr, data};
        in_v = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) timed_out = 1;
        @(posedge clk);
        @(negedge clk);
        in_v = 1'b0;
        first_hv = hv;
        first_dv = dv;
        cyc = 0;
        done = 0;
        while (!done) begin
            if (ph && (hv !== 1'b1 || hdr_o !== prev_hdr)) stable_err++;
            if (pd && (dv !== 1'b1 || data_o !== prev_data)) stable_err++;
            if ((hv || dv) && in_ready) busy_accept_err++;
            if (!hv && !dv) begin
                done = 1;
                ready_after = in_ready;
            end else if (cyc >= 300) begin
                done = 1;
                timed_out = 1;
            end else begin
                hr = ($urandom_range(0, 99) >= hst);
                dr = ($urandom_range(0, 99) >= dst);
                if (dv) ever_dv = 1;
                if (hv && hr) begin
                    got_hdr = hdr_o;
                    got_hdr_cnt++;
                end
                if (dv && dr) begin
                    if (got_beat_cnt < 16) got_beats[got_beat_cnt] = data_o;
                    got_beat_cnt++;
                end
                ph = hv && !hr;
                pd = dv && !dr;
                prev_hdr = hdr_o;
                prev_data = data_o;
                @(negedge clk);
                cyc++;
            end
        end
        hr = 1'b0;
        dr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({in_ready, hv, dv} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got ready/hv/dv=%b want 000", {in_ready, hv, dv});
        end
        reset_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({in_ready, hv, dv} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL post_reset: got ready/hv/dv=%b want 100", {in_ready, hv, dv});
        end
    endtask

    task automatic test_write64();
        logic [HW-1:0] h;
        h = make_hdr(T_WRITE, 3'd6, 40'h12_3456_7840, 16'hA5A5);
        run_msg(h, counting_data(), 0, 0);
        compared++;
        if (timed_out || {first_hv, first_dv} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL w64_latency: got to=%0d hv/dv=%b want to=0 hv/dv=11", timed_out, {first_hv, first_dv});
        end
        compared++;
        if (got_hdr_cnt !== 1 || got_hdr !== h) begin
            mismatched++;
            $display("[TB] FAIL w64_header: got cnt=%0d hdr=%h want cnt=1 hdr=%h", got_hdr_cnt, got_hdr, h);
        end
        compared++;
        if (got_beat_cnt !== 8) begin
            mismatched++;
            $display("[TB] FAIL w64_beat_count: got %0d want 8", got_beat_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (got_beats[i] !== ODW'(i)) begin
                mismatched++;
                $display("[TB] FAIL w64_beat%0d: got %h want %h", i, got_beats[i], ODW'(i));
            end
        end
    endtask

    task automatic test_write8();
        logic [HW-1:0]  h;
        logic [IDW-1:0] d;
        h = make_hdr(T_WRITE, 3'd3, 40'h00_0000_1008, 16'h0003);
        d = random_data();
        d[63:0] = 64'hDEAD_BEEF_0123_4567;
        run_msg(h, d, 0, 0);
        compared++;
        if (got_beat_cnt !== 1 || got_beats[0] !== 64'hDEAD_BEEF_0123_4567) begin
            mismatched++;
            $display("[TB] FAIL w8_beat: got cnt=%0d data=%h want cnt=1 data=deadbeef01234567", got_beat_cnt, got_beats[0]);
        end
        compared++;
        if (got_hdr !== h || ready_after !== 1'b1 || timed_out) begin
            mismatched++;
            $display("[TB] FAIL w8_hdr_ready: got hdr=%h ready=%b to=%0d want hdr=%h ready=1 to=0", got_hdr, ready_after, timed_out, h);
        end
    endtask

    task automatic test_read();
        logic [HW-1:0] h;
        h = make_hdr(T_READ, 3'd6, 40'h00_0000_2000, 16'h0044);
        run_msg(h, random_data(), 0, 0);
        compared++;
        if (ever_dv || first_dv || got_beat_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL read_no_data: got dv_seen=%0d beats=%0d want 0 0", ever_dv, got_beat_cnt);
        end
        compared++;
        if (got_hdr_cnt !== 1 || got_hdr !== h || ready_after !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL read_header: got cnt=%0d hdr=%h ready=%b want 1 %h 1", got_hdr_cnt, got_hdr, ready_after, h);
        end
    endtask

    task automatic test_sizes();
        logic [HW-1:0] h;
        h = make_hdr(T_WRITE, 3'd0, 40'h00_0000_3001, 16'h0001);
        run_msg(h, counting_data(), 0, 0);
        compared++;
        if (got_beat_cnt !== 1 || got_beats[0] !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL size1B_beats: got cnt=%0d data=%h want 1 0", got_beat_cnt, got_beats[0]);
        end
        h = make_hdr(T_WRITE, 3'd7, 40'h00_0000_4000, 16'h0002);
        run_msg(h, counting_data(), 0, 0);
        compared++;
        if (got_beat_cnt !== 8 || got_beats[7] !== 64'd7 || got_hdr !== h) begin
            mismatched++;
            $display("[TB] FAIL size128B_clamp: got cnt=%0d last=%h hdr=%h want 8 7 %h", got_beat_cnt, got_beats[7], got_hdr, h);
        end
        h = make_hdr(T_WRITE, 3'd4, 40'h00_0000_5000, 16'h0003);
        run_msg(h, counting_data(), 0, 0);
        compared++;
        if (got_beat_cnt !== 2 || got_beats[1] !== 64'd1) begin
            mismatched++;
            $display("[TB] FAIL size16B_beats: got cnt=%0d beat1=%h want 2 1", got_beat_cnt, got_beats[1]);
        end
    endtask

    task automatic test_stall();
        logic [HW-1:0] h;
        int bad;
        for (int m = 0; m < 4; m++) begin
            h = make_hdr(T_WRITE, 3'd6, 40'(m * 64), 16'(m));
            run_msg(h, counting_data(), (m % 2 == 0) ? 80 : 40, 50);
            bad = 0;
            for (int i = 0; i < 8; i++) if (got_beats[i] !== ODW'(i)) bad++;
            compared++;
            if (bad != 0 || got_beat_cnt !== 8 || got_hdr_cnt !== 1 || got_hdr !== h) begin
                mismatched++;
                $display("[TB] FAIL stall_order m%0d: got bad=%0d beats=%0d hdrs=%0d want 0 8 1", m, bad, got_beat_cnt, got_hdr_cnt);
            end
            compared++;
            if (stable_err != 0 || busy_accept_err != 0 || timed_out) begin
                mismatched++;
                $display("[TB] FAIL stall_stable m%0d: got unstable=%0d busy_ready=%0d to=%0d want 0 0 0", m, stable_err, busy_accept_err, timed_out);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int bad;
        @(negedge clk);
        in_msg = {make_hdr(T_WRITE, 3'd6, 40'h00_0000_6000, 16'h0006), counting_data()};
        in_v = 1'b1;
        hr = 1'b1;
        dr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_v = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (dv !== 1'b1 || data_o !== 64'd3) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_beat3: got dv=%b data=%h want 1 3", dv, data_o);
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if ({in_ready, hv, dv} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_gate: got ready/hv/dv=%b want 000", {in_ready, hv, dv});
        end
        repeat (2) @(negedge clk);
        compared++;
        if ({in_ready, hv, dv} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_hold: got ready/hv/dv=%b want 000", {in_ready, hv, dv});
        end
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dv !== 1'b0 || hv !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_after: got %0d bad cycles want 0", bad);
        end
        hr = 1'b0;
        dr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [HW-1:0]  h;
        logic [IDW-1:0] d;
        logic [3:0]     t;
        logic [2:0]     s;
        int n, bad;
        for (int m = 0; m < 100; m++) begin
            t = ($urandom_range(0, 1) == 1) ? T_WRITE : T_READ;
            s = 3'($urandom_range(0, 7));
            h = make_hdr(t, s, {8'h00, 32'($urandom)}, 16'($urandom));
            d = random_data();
            run_msg(h, d, $urandom_range(0, 30), $urandom_range(0, 30));
            n = exp_beats(t, s);
            bad = 0;
            for (int i = 0; i < n; i++) if (got_beats[i] !== d[i*ODW +: ODW]) bad++;
            compared++;
            if (got_hdr !== h || got_hdr_cnt !== 1 || got_beat_cnt !== n || bad != 0) begin
                mismatched++;
                $display("[TB] FAIL b2b m%0d: got hdrs=%0d beats=%0d bad=%0d want 1 %0d 0", m, got_hdr_cnt, got_beat_cnt, bad, n);
            end
            compared++;
            if (stable_err != 0 || busy_accept_err != 0 || timed_out || ready_after !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_flow m%0d: got unstable=%0d busy=%0d to=%0d ready=%b want 0 0 0 1", m, stable_err, busy_accept_err, timed_out, ready_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write64();
        test_write8();
        test_read();
        test_sizes();
        test_stall();
        test_reset_mid_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
